// File: rtl/bus_arbiter8_pkg.sv
// Shared types and constants for the eight-way round-robin result-bus arbiter.
package bus_arbiter8_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;
endpackage

// File: rtl/bus_arbiter8_if.sv
// Request/data/grant bundle between the eight producers and the arbiter.
interface bus_arbiter8_if;
  import bus_arbiter8_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  din0, din1, din2, din3, din4, din5, din6, din7;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [SEL_W-1:0]   sel;
  logic [DATA_W-1:0]  dout;
  logic               dout_valid;

  modport master (
    output req, din0, din1, din2, din3, din4, din5, din6, din7,
    input  gnt, gnt_valid, sel, dout, dout_valid
  );

  modport slave (
    input  req, din0, din1, din2, din3, din4, din5, din6, din7,
    output gnt, gnt_valid, sel, dout, dout_valid
  );
endinterface

// File: rtl/bus_arbiter8_mux.sv
// 8:1 32-bit word mux; select bits C2 (msb) .. C0 (lsb) choose among I7..I0.
module mux8to1B32 (
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  input  logic [31:0] I3,
  input  logic [31:0] I4,
  input  logic [31:0] I5,
  input  logic [31:0] I6,
  input  logic [31:0] I7,
  input  logic        C2,
  input  logic        C1,
  input  logic        C0,
  output logic [31:0] Y
);
  always_comb begin
    case ({C2, C1, C0})
      3'd0:    Y = I0;
      3'd1:    Y = I1;
      3'd2:    Y = I2;
      3'd3:    Y = I3;
      3'd4:    Y = I4;
      3'd5:    Y = I5;
      3'd6:    Y = I6;
      default: Y = I7;
    endcase
  end
endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter for one 32-bit result bus: sticky grants bounded by MAX_HOLD,
// with a registered copy of the selected producer word.
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  bus_arbiter8_if.slave  bus
);
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic [NUM_REQ-1:0] others;
  pick_t              pick_req, pick_oth;
  logic [DATA_W-1:0]  mux_y;
  logic [DATA_W-1:0]  dout_p1;
  logic               vld_p1;

  // First set bit of mask scanning ptr, ptr+1, ... modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] mask,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            p;
    logic [SEL_W-1:0] idx;
    p = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (mask[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    others   = bus.req & ~(NUM_REQ'(1) << owner_q);
    pick_req = rr_pick(bus.req, ptr_q);
    pick_oth = rr_pick(others, ptr_q);
    case (state_q)
      IDLE: begin
        if (pick_req.found) begin
          state_d = OWN;
          owner_d = pick_req.idx;
          ptr_d   = pick_req.idx + SEL_W'(1);
          hold_d  = '0;
        end
      end
      default: begin
        if (bus.req[owner_q]) begin
          if (hold_q != HC_W'(MAX_HOLD - 1)) begin
            hold_d = hold_q + HC_W'(1);
          end else begin
            // Hold budget spent: yield only if someone else is waiting.
            hold_d = '0;
            if (pick_oth.found) begin
              owner_d = pick_oth.idx;
              ptr_d   = pick_oth.idx + SEL_W'(1);
            end
          end
        end else if (pick_req.found) begin
          owner_d = pick_req.idx;
          ptr_d   = pick_req.idx + SEL_W'(1);
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
    endcase
  end

  assign bus.gnt_valid = (state_q == OWN);
  assign bus.gnt       = bus.gnt_valid ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.sel       = bus.gnt_valid ? owner_q : '0;

  mux8to1B32 u_mux (
    .I0 (bus.din0),
    .I1 (bus.din1),
    .I2 (bus.din2),
    .I3 (bus.din3),
    .I4 (bus.din4),
    .I5 (bus.din5),
    .I6 (bus.din6),
    .I7 (bus.din7),
    .C2 (bus.sel[2]),
    .C1 (bus.sel[1]),
    .C0 (bus.sel[0]),
    .Y  (mux_y)
  );

  // Stage p1: captured word from the owner of the previous cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.gnt_valid;
      if (bus.gnt_valid) begin
        dout_p1 <= mux_y;
      end
    end
  end

  assign bus.dout       = dout_p1;
  assign bus.dout_valid = vld_p1;
endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8 (MAX_HOLD=4): reset, forced rotation, bursts,
// bubble-free handoff, round-robin order and reset during a grant.
module tb_bus_arbiter8;
  import bus_arbiter8_pkg::*;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  bus_arbiter8_if bus ();

  bus_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  rot_gnt [12];
  logic [31:0] rot_din [12];

  initial begin
    tests = 0;
    fails = 0;
    reset_n  = 1'b0;
    bus.req  = 8'hFF;
    bus.din0 = 32'h1000_0000;
    bus.din1 = 32'h1111_1111;
    bus.din2 = 32'h2222_2222;
    bus.din3 = 32'h3333_3333;
    bus.din4 = 32'h4444_4444;
    bus.din5 = 32'h5555_5555;
    bus.din6 = 32'h6666_6666;
    bus.din7 = 32'h7777_7777;

    // Reset held three cycles with everyone requesting.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt",  32'(bus.gnt), 32'h0);
      chk("rst_sel",  32'(bus.sel), 32'h0);
      chk("rst_dout", bus.dout, 32'h0);
      chk("rst_dval", 32'(bus.dout_valid), 32'h0);
    end
    reset_n = 1'b1;

    // First grant is requester 0; then only 0 and 7 request -> 4/4 rotation.
    for (int i = 0; i < 12; i++) begin
      rot_gnt[i] = ((i / 4) % 2 == 1) ? 8'h80 : 8'h01;
      rot_din[i] = ((i / 4) % 2 == 1) ? 32'h7777_7777 : 32'h1000_0000;
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) bus.req = 8'h81;
      chk("rot_gnt", 32'(bus.gnt), 32'(rot_gnt[i]));
      chk("rot_gv",  32'(bus.gnt_valid), 32'h1);
      if (i == 0) begin
        chk("rot_dval0", 32'(bus.dout_valid), 32'h0);
      end else begin
        chk("rot_dval", 32'(bus.dout_valid), 32'h1);
        chk("rot_dout", bus.dout, rot_din[i-1]);
      end
    end
    bus.req = 8'h00;
    step();
    chk("idle_gnt",  32'(bus.gnt), 32'h0);
    chk("idle_gv",   32'(bus.gnt_valid), 32'h0);
    chk("idle_dval", 32'(bus.dout_valid), 32'h1);
    chk("idle_dout", bus.dout, 32'h1000_0000);
    step();
    chk("idle_dval2", 32'(bus.dout_valid), 32'h0);
    chk("idle_hold",  bus.dout, 32'h1000_0000);

    // Single 5-cycle burst from requester 3 alone: holds past MAX_HOLD.
    bus.din3 = 32'hDEAD_BEEF;
    bus.req  = 8'h08;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("burst_gnt", 32'(bus.gnt), 32'h08);
      chk("burst_sel", 32'(bus.sel), 32'h3);
      if (i > 0) begin
        chk("burst_dout", bus.dout, 32'hDEAD_BEEF);
        chk("burst_dval", 32'(bus.dout_valid), 32'h1);
      end
    end
    bus.req = 8'h00;
    step();
    chk("burst_end_gnt",  32'(bus.gnt), 32'h0);
    chk("burst_end_dout", bus.dout, 32'hDEAD_BEEF);
    chk("burst_end_dval", 32'(bus.dout_valid), 32'h1);
    step();
    chk("burst_end_dval2", 32'(bus.dout_valid), 32'h0);

    // Handoff 2 -> 5 with no bubble.
    bus.req = 8'h04;
    step();
    chk("ho_gnt2", 32'(bus.gnt), 32'h04);
    step();
    chk("ho_gnt2b", 32'(bus.gnt), 32'h04);
    bus.req = 8'h20;
    step();
    chk("ho_gnt5", 32'(bus.gnt), 32'h20);
    chk("ho_gv",   32'(bus.gnt_valid), 32'h1);
    chk("ho_sel",  32'(bus.sel), 32'h5);
    chk("ho_dout", bus.dout, 32'h2222_2222);

    // Round-robin: 5 releases with {0,1,6} waiting -> 6; then {0,1} -> 0.
    bus.req = 8'h43;
    step();
    chk("rr_gnt6", 32'(bus.gnt), 32'h40);
    bus.req = 8'h03;
    step();
    chk("rr_gnt0", 32'(bus.gnt), 32'h01);
    chk("rr_gv",   32'(bus.gnt_valid), 32'h1);

    // Reset while requester 4 owns with valid data in flight.
    bus.req = 8'h10;
    step();
    chk("mr_gnt4", 32'(bus.gnt), 32'h10);
    step();
    chk("mr_dout4", bus.dout, 32'h4444_4444);
    chk("mr_dval4", 32'(bus.dout_valid), 32'h1);
    reset_n = 1'b0;
    step();
    chk("mr_gnt",  32'(bus.gnt), 32'h0);
    chk("mr_gv",   32'(bus.gnt_valid), 32'h0);
    chk("mr_sel",  32'(bus.sel), 32'h0);
    chk("mr_dout", bus.dout, 32'h0);
    chk("mr_dval", 32'(bus.dout_valid), 32'h0);
    reset_n = 1'b1;
    bus.req = 8'hFF;
    step();
    chk("mr_ptr0", 32'(bus.gnt), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
